// File: rtl/core_irq_timer_pkg.sv
// Shared constants for the machine timer block: register offsets, access FSM
// encoding, the latched request record and the byte-merge helper.
package core_irq_timer_pkg;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [15:0] off;
        logic [31:0] data;
        logic        wen;
        logic [3:0]  be;
    } req_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/core_irq_timer_counter.sv
// 64-bit mtime counter with byte-wise half loads and an optional prescaler.
// Prescaler is built only when CORE_IRQ_TIMER_PRESCALE_EN is defined.
module core_irq_timer_counter
    import core_irq_timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_lo_i,
    input  logic        load_hi_i,
    input  logic [31:0] load_data_i,
    input  logic [3:0]  load_be_i,
    output logic [63:0] mtime_o
);

    logic [63:0] mtime_q, mtime_d;
    logic        tick;
    logic        load;

    assign load = load_lo_i | load_hi_i;

`ifdef CORE_IRQ_TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;

    always_comb begin
        tick    = (presc_q == PRESCALE - 16'd1);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        // A software write to mtime restarts the tick period from zero.
        if (load) begin
            presc_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    // A load wins over a tick on the same edge; the other half is left as-is.
    always_comb begin
        mtime_d = mtime_q;
        if (load_lo_i) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], load_data_i, load_be_i);
        end
        if (load_hi_i) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], load_data_i, load_be_i);
        end
        if (!load && tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q <= 64'd0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/core_irq_timer.sv
// Memory-mapped machine timer / software interrupt block (msip, mtime, mtimecmp).
// Define CORE_IRQ_TIMER_PRESCALE_EN to divide the mtime tick by PRESCALE.
//
// state | meaning
// IDLE  | no access pending, memReady high
// WAIT  | access latched, memReady low while the wait counter runs down
// RESP  | write committed, read data on dataout for exactly one cycle
module core_irq_timer
    import core_irq_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned ACCESS_WAIT = 1,
    parameter logic [15:0] PRESCALE    = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    input  logic        wen,
    input  logic        ren,
    input  logic [3:0]  byte_select_vector,
    output logic [31:0] dataout,
    output logic        memReady,
    output logic        software_interrupt,
    output logic        timer_interrupt
);

    localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    req_t        req_q, req_d;
    logic [31:0] dataout_q, dataout_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        timer_q;
    logic [63:0] mtime;
    logic        sel;
    logic        commit;
    logic        wr;
    logic [31:0] rdata;

    assign sel    = (ren | wen) && (address[31:16] == BASE_ADDR[31:16]);
    assign commit = (state_q == ST_WAIT) && (wait_q == 4'd1);
    assign wr     = commit && req_q.wen;

    // Read value is taken before the write lands, which gives the
    // read-old-value behaviour for combined read/write requests.
    always_comb begin
        rdata = 32'd0;
        case (req_q.off)
            OFF_MSIP:        rdata = {31'd0, msip_q};
            OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            OFF_MTIME_LO:    rdata = mtime[31:0];
            OFF_MTIME_HI:    rdata = mtime[63:32];
            default:         rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        req_d     = req_q;
        dataout_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    state_d    = ST_WAIT;
                    wait_d     = WAIT_LOAD;
                    req_d.off  = address[15:0];
                    req_d.data = datain;
                    req_d.wen  = wen;
                    req_d.be   = byte_select_vector;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd1) begin
                    state_d   = ST_RESP;
                    dataout_d = rdata;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr) begin
            case (req_q.off)
                OFF_MSIP: begin
                    if (req_q.be[0]) begin
                        msip_d = req_q.data[0];
                    end
                end
                OFF_MTIMECMP_LO:
                    mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], req_q.data, req_q.be);
                OFF_MTIMECMP_HI:
                    mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_q.data, req_q.be);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_q     <= 4'd0;
            req_q      <= '0;
            dataout_q  <= 32'd0;
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            dataout_q  <= dataout_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            timer_q    <= (mtime >= mtimecmp_q);
        end
    end

    core_irq_timer_counter #(
        .PRESCALE(PRESCALE)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_lo_i  (wr && (req_q.off == OFF_MTIME_LO)),
        .load_hi_i  (wr && (req_q.off == OFF_MTIME_HI)),
        .load_data_i(req_q.data),
        .load_be_i  (req_q.be),
        .mtime_o    (mtime)
    );

    assign memReady           = (state_q != ST_WAIT);
    assign dataout            = dataout_q;
    assign software_interrupt = msip_q;
    assign timer_interrupt    = timer_q;

endmodule

// File: tb/tb_core_irq_timer.sv
// Scoreboard bench for core_irq_timer: a driver issues bus accesses and
// queues expected read data; a monitor checks every response and interrupt.
`timescale 1ns/1ps
module tb_core_irq_timer;

    localparam int          TB_WAIT = 3;
    localparam logic [31:0] BASE    = 32'h0200_0000;
`ifdef CORE_IRQ_TIMER_PRESCALE_EN
    localparam longint TB_PRESC = 4;
`else
    localparam longint TB_PRESC = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] datain = 32'd0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [3:0]  byte_select_vector = 4'd0;
    logic [31:0] dataout;
    logic        memReady;
    logic        software_interrupt;
    logic        timer_interrupt;

    core_irq_timer #(
        .BASE_ADDR  (BASE),
        .ACCESS_WAIT(TB_WAIT),
        .PRESCALE   (16'd4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .datain            (datain),
        .wen               (wen),
        .ren               (ren),
        .byte_select_vector(byte_select_vector),
        .dataout           (dataout),
        .memReady          (memReady),
        .software_interrupt(software_interrupt),
        .timer_interrupt   (timer_interrupt)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint edge_n = 0;

    // Register history: value holding from edge e onward (mtime: base value at e).
    typedef struct {
        longint      e;
        logic [63:0] v;
    } chg_t;
    chg_t msip_h[$];
    chg_t cmp_h[$];
    chg_t mt_h[$];

    typedef struct {
        logic [31:0] data;
        logic [15:0] off;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [63:0] val_at(input int which, input longint n);
        logic [63:0] v;
        v = 64'd0;
        case (which)
            0: foreach (msip_h[i]) if (msip_h[i].e <= n) v = msip_h[i].v;
            1: foreach (cmp_h[i]) if (cmp_h[i].e <= n) v = cmp_h[i].v;
            default: foreach (mt_h[i])
                if (mt_h[i].e <= n) v = mt_h[i].v + 64'((n - mt_h[i].e) / TB_PRESC);
        endcase
        return v;
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Access latched on edge n_s commits on edge n_s+TB_WAIT; reads see the prior state.
    task automatic model_access(input logic [15:0] off, input logic [31:0] d, input logic w,
                                input logic [3:0] be, input longint n_s, output logic [31:0] r);
        longint      nc;
        logic [63:0] ms, cm, mt;
        nc = n_s + TB_WAIT;
        ms = val_at(0, nc - 1);
        cm = val_at(1, nc - 1);
        mt = val_at(2, nc - 1);
        case (off)
            16'h0000: r = {31'd0, ms[0]};
            16'h4000: r = cm[31:0];
            16'h4004: r = cm[63:32];
            16'hBFF8: r = mt[31:0];
            16'hBFFC: r = mt[63:32];
            default:  r = 32'd0;
        endcase
        if (w) begin
            case (off)
                16'h0000: if (be[0]) msip_h.push_back('{nc, {63'd0, d[0]}});
                16'h4000: cmp_h.push_back('{nc, {cm[63:32], bmerge(cm[31:0], d, be)}});
                16'h4004: cmp_h.push_back('{nc, {bmerge(cm[63:32], d, be), cm[31:0]}});
                16'hBFF8: mt_h.push_back('{nc, {mt[63:32], bmerge(mt[31:0], d, be)}});
                16'hBFFC: mt_h.push_back('{nc, {bmerge(mt[63:32], d, be), mt[31:0]}});
                default: ;
            endcase
        end
    endtask

    // Called on a negedge with the DUT idle; hold keeps the request up for a second access.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic r, input logic [3:0] be, input bit hold);
        longint      n_s, last;
        logic [31:0] pre;
        bit          sel;
        sel = (a[31:16] == BASE[31:16]) && (w || r);
        address = a; datain = d; wen = w; ren = r; byte_select_vector = be;
        n_s  = edge_n + 1;
        last = n_s;
        if (sel) begin
            model_access(a[15:0], d, w, be, n_s, pre);
            exp_q.push_back('{pre, a[15:0]});
            if (hold) begin
                last = n_s + TB_WAIT + 2;
                model_access(a[15:0], d, w, be, last, pre);
                exp_q.push_back('{pre, a[15:0]});
            end
        end
        while (edge_n < last) @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        address = $urandom; datain = $urandom; byte_select_vector = 4'($urandom);
        if (sel) begin
            while (edge_n < last + TB_WAIT + 1) @(negedge clk);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0; wen = 1'b0; ren = 1'b0;
        repeat (cycles) @(negedge clk);
        chk("rst_memready", memReady, 1);
        chk("rst_dataout", dataout, 0);
        chk("rst_swirq", software_interrupt, 0);
        chk("rst_tirq", timer_interrupt, 0);
        reset = 1'b1;
        exp_q.delete(); msip_h.delete(); cmp_h.delete(); mt_h.delete();
        msip_h.push_back('{edge_n, 64'd0});
        cmp_h.push_back('{edge_n, 64'hFFFF_FFFF_FFFF_FFFF});
        mt_h.push_back('{edge_n, 64'd0});
    endtask

    initial begin : monitor
        bit          prev_rdy;
        int          low_cnt;
        exp_t        e;
        logic [63:0] ms;
        prev_rdy = 1'b1;
        low_cnt  = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (!reset) begin
                prev_rdy = 1'b1;
                low_cnt  = 0;
            end else begin
                if (memReady && !prev_rdy) begin
                    chk("wait_cycles", 64'(low_cnt), 64'(TB_WAIT));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 64'(dataout), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rdata_%h", e.off), dataout, e.data);
                    end
                end else begin
                    chk("dataout_zero", dataout, 0);
                end
                low_cnt  = memReady ? 0 : low_cnt + 1;
                prev_rdy = memReady;
                ms = val_at(0, edge_n);
                chk("sw_irq", software_interrupt, ms[0]);
                chk("timer_irq", timer_interrupt,
                    {63'd0, (val_at(2, edge_n - 1) >= val_at(1, edge_n - 1))});
            end
        end
    end

    initial begin : driver
        logic [31:0] a, d;
        logic [3:0]  be;
        int          pick, rw;
        logic [15:0] offs [5];
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};

        do_reset(3);
        access(BASE + 32'h4004, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'h1234, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'h4000, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE, 32'h1, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'h1234, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 1'b0);
        access(32'h0300_0000, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0);
        access(BASE, 32'h1, 1'b1, 1'b0, 4'hE, 1'b0);

        do_reset(2);
        access(BASE + 32'h4004, 32'd0, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE + 32'h4000, 32'd20, 1'b1, 1'b0, 4'hF, 1'b0);
        repeat (30 * TB_PRESC) @(negedge clk);
        access(BASE + 32'h4004, 32'h1, 1'b1, 1'b0, 4'hF, 1'b0);
        repeat (3) @(negedge clk);

        access(BASE + 32'hBFFC, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE + 32'hBFF8, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE + 32'hBFFC, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'hBFFC, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE + 32'hBFF8, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 1'b0);
        access(BASE + 32'hBFFC, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'hBFF8, 32'h0, 1'b0, 1'b1, 4'hF, 1'b1);
        access(BASE + 32'h4000, 32'h1234_5678, 1'b1, 1'b1, 4'h5, 1'b0);

        for (int i = 0; i < 120; i++) begin
            pick = $urandom_range(0, 7);
            if (pick < 5) a = BASE | {16'd0, offs[pick]};
            else if (pick == 5) a = BASE | ($urandom & 32'h0000_FFFC);
            else a = {16'h0100 + 16'($urandom_range(0, 2)), 16'h0000};
            d  = $urandom;
            be = 4'($urandom);
            rw = $urandom_range(1, 3);
            access(a, d, rw[1], rw[0], be, ($urandom_range(0, 5) == 0));
        end

        do_reset(2);
        address = BASE; datain = 32'h1; wen = 1'b1; ren = 1'b0; byte_select_vector = 4'hF;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        chk("abort_in_wait", memReady, 0);
        reset = 1'b0;
        #1;
        chk("abort_memready", memReady, 1);
        chk("abort_dataout", dataout, 0);
        chk("abort_swirq", software_interrupt, 0);
        @(negedge clk);
        do_reset(2);
        access(BASE, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        access(BASE + 32'hBFF8, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);
        repeat (5) @(negedge clk);
        access(BASE + 32'hBFF8, 32'h0, 1'b0, 1'b1, 4'hF, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_irq_timer.md
CORE_IRQ_TIMER -- requirements
Module: core_irq_timer

Interface
REQ-001 The block SHALL take parameter BASE_ADDR, default 32'h0200_0000: the 64 KiB-aligned base of the register window.
REQ-002 The block SHALL take parameter ACCESS_WAIT, default 1: the number of memReady-low cycles per access (range 1..15).
REQ-003 The block SHALL take parameter PRESCALE, default 16'd1: the clk cycles per mtime tick (range 1..65535).
REQ-004 Port clk SHALL be input, width 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset SHALL be input, width 1: asynchronous, active-low reset.
REQ-006 Port address SHALL be input, width 32: the data-bus address.
REQ-007 Port datain SHALL be input, width 32: the write data from the CPU.
REQ-008 Port wen SHALL be input, width 1: the write request.
REQ-009 Port ren SHALL be input, width 1: the read request.
REQ-010 Port byte_select_vector SHALL be input, width 4: the per-byte write enables.
REQ-011 Port dataout SHALL be output, width 32: the read data to the CPU.
REQ-012 Port memReady SHALL be output, width 1: high when no access is pending; the CPU ANDs it with the other responders' ready signals.
REQ-013 Port software_interrupt SHALL be output, width 1: msip bit 0.
REQ-014 Port timer_interrupt SHALL be output, width 1: the registered result of mtime >= mtimecmp.

Function
REQ-015 The block SHALL treat an access as selected when (ren|wen)=1 and address[31:16]==BASE_ADDR[31:16]; unselected accesses SHALL be ignored with memReady held at 1.
REQ-016 The register map (offset=address[15:0]) SHALL be: 0x0000 msip (bit0 only, others read 0); 0x4000/0x4004 mtimecmp lo/hi; 0xBFF8/0xBFFC mtime lo/hi; all other offsets read 0 and ignore writes.
REQ-017 The access FSM SHALL have states IDLE, WAIT, RESP.
- IDLE: memReady=1. A selected access moves to WAIT and loads the wait counter with ACCESS_WAIT.
- WAIT: memReady=0; the counter decrements each cycle; on reaching 1 the FSM moves to RESP.
- RESP: memReady=1 for exactly one cycle, then IDLE.
REQ-018 The block SHALL latch address, datain, wen and byte_select_vector on the IDLE->WAIT edge; later bus changes SHALL NOT affect the access in flight.
REQ-019 On the WAIT->RESP edge, the write SHALL commit byte-wise under the latched byte_select_vector, and read data SHALL be captured into dataout.
REQ-020 dataout SHALL be valid only in RESP and SHALL be 0 in every other cycle.
REQ-021 If wen and ren are both set, the access SHALL be a write, and dataout SHALL return the pre-write register value.
REQ-022 A selected request still asserted in the cycle after RESP SHALL start a new access.
REQ-023 mtime SHALL be a 64-bit counter that increments by 1 per tick and wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-024 A write to either mtime half SHALL take precedence over a tick on the same edge; that write SHALL also clear the prescale counter.
REQ-025 timer_interrupt SHALL equal the unsigned 64-bit compare (mtime >= mtimecmp) registered once, i.e. one cycle of latency.
REQ-026 timer_interrupt SHALL be level-sensitive and deassert one cycle after mtimecmp is written above mtime.
REQ-027 software_interrupt SHALL follow msip bit 0 with no added latency after the commit edge.

Reset
REQ-028 While reset=0, asynchronously: FSM=IDLE, memReady=1, dataout=0, msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale counter=0, timer_interrupt=0, software_interrupt=0.
REQ-029 Reset asserted mid-access SHALL abort the access with no register write.

Configuration
REQ-030 With macro CORE_IRQ_TIMER_PRESCALE_EN defined, a 16-bit prescale counter SHALL emit a tick every PRESCALE cycles, counting 0..PRESCALE-1.
REQ-031 Without CORE_IRQ_TIMER_PRESCALE_EN, mtime SHALL tick every cycle, PRESCALE SHALL be ignored, and no prescale counter SHALL be built.

Structure
REQ-032 The shared package SHALL hold the register offset constants (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI) and the FSM state encoding.
REQ-033 The mtime counter and prescaler SHALL be one sub-module, core_irq_timer_counter (inputs: load-lo, load-hi, load data, byte mask; output: 64-bit mtime).

Verification
REQ-034 Default parameters, write 32'h1 to 0x0200_0000, byte_select 4'hF -> memReady low 1 cycle; software_interrupt=1 on the cycle after RESP; read of 0x0200_0000 returns 32'h1.
REQ-035 Write mtimecmp lo=32'd20, hi=0 after reset (prescale off) -> timer_interrupt rises on the cycle after mtime reaches 20; then writing mtimecmp hi=32'h1 drops it one cycle later.
REQ-036 Write mtime lo=32'hFFFF_FFFF, hi=32'h0 -> a read of mtime hi two ticks later returns 32'h1 (carry); separately, mtime=all-ones wraps to 0.
REQ-037 ACCESS_WAIT=3, read 0x0200_4004 -> memReady low exactly 3 cycles; dataout=32'hFFFF_FFFF in RESP only; read of 0x0200_1234 returns 0.
REQ-038 Pull reset low during WAIT of a msip write -> memReady=1 immediately, msip stays 0; with the macro defined and PRESCALE=4, mtime advances 1 per 4 cycles after release.
